write_eeprom: RTL

Writes a block of bytes to an I2C EEPROM through the existing i2c_master byte engine. This is the write-side counterpart of the EEPROM read controller.
- Splits each request into page-aligned chunks.
- For each chunk, sends the 2-byte memory address followed by the data bytes.
- Waits a fixed internal write-cycle time before the next chunk.
- Data enters through a one-byte valid/ready buffer from the user side.

---
 rtl/eeprom_pkg.sv | 27 ++
 rtl/write_eeprom_if.sv | 25 ++
 rtl/eeprom_page_splitter.sv | 54 +++++
 rtl/write_eeprom.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eeprom_pkg: state encoding and constants shared by the EEPROM        |
// | read/write controllers.                          Revision: 1.0       |
// +----------------------------------------------------------------------+
package eeprom_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START       = 3'd1,
    ADDR_HI     = 3'd2,
    ADDR_LO     = 3'd3,
    DATA        = 3'd4,
    WAIT_STOP   = 3'd5,
    WRITE_CYCLE = 3'd6
  } eeprom_state_t;

  localparam logic READ       = 1'b1;
  localparam logic WRITE      = 1'b0;
  localparam int   ADDR_BYTES = 2;

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/write_eeprom_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | write_eeprom_if: byte-engine bus between the EEPROM write controller |
// | and i2c_master.                                  Revision: 1.0       |
// +----------------------------------------------------------------------+
interface write_eeprom_if;
  logic [6:0] i2c_slave_addr;
  logic       i2c_rw;
  logic [7:0] i2c_write_data;
  logic [7:0] i2c_nbytes;
  logic       i2c_start;
  logic       i2c_tx_data_req;
  logic       i2c_busy;

  modport master (
    output i2c_slave_addr, i2c_rw, i2c_write_data, i2c_nbytes, i2c_start,
    input  i2c_tx_data_req, i2c_busy
  );

  modport slave (
    input  i2c_slave_addr, i2c_rw, i2c_write_data, i2c_nbytes, i2c_start,
    output i2c_tx_data_req, i2c_busy
  );
endinterface
`default_nettype wire

// File: rtl/eeprom_page_splitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eeprom_page_splitter: holds the running address/byte count and       |
// | yields the next page-bounded chunk.              Revision: 1.0       |
// +----------------------------------------------------------------------+
module eeprom_page_splitter
  import eeprom_pkg::*;
#(
  parameter int PAGE_SIZE = 64
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        load,
  input  wire logic [15:0] load_addr,
  input  wire logic [7:0]  load_count,
  input  wire logic        advance,
  output logic      [15:0] addr,
  output logic      [7:0]  remaining,
  output logic      [7:0]  chunk
);

  localparam logic [7:0] c_page_size = 8'(PAGE_SIZE);
  localparam logic [7:0] c_page_mask = c_page_size - 8'd1;

  logic [15:0] r_addr;
  logic [7:0]  r_remaining;
  logic [7:0]  w_offset;
  logic [7:0]  w_space;
  logic [7:0]  w_chunk;

  // Bytes left before the page boundary; never zero since offset < PAGE_SIZE
  assign w_offset = r_addr[7:0] & c_page_mask;
  assign w_space  = c_page_size - w_offset;
  assign w_chunk  = min8(r_remaining, w_space);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= 16'h0000;
      r_remaining <= 8'h00;
    end else if (load) begin
      r_addr      <= load_addr;
      r_remaining <= load_count;
    end else if (advance) begin
      r_addr      <= r_addr + {8'h00, w_chunk};
      r_remaining <= r_remaining - w_chunk;
    end
  end

  assign addr      = r_addr;
  assign remaining = r_remaining;
  assign chunk     = w_chunk;

endmodule
`default_nettype wire

// File: rtl/write_eeprom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | write_eeprom: page-split block writes to an I2C EEPROM through the   |
// | i2c_master byte engine.                          Revision: 1.0       |
// +----------------------------------------------------------------------+
module write_eeprom
  import eeprom_pkg::*;
#(
  parameter int PAGE_SIZE   = 64,
  parameter int T_WR_CYCLES = 250000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [6:0]  slave_addr_w,
  input  wire logic [15:0] mem_addr_w,
  input  wire logic [7:0]  write_nbytes_w,
  input  wire logic        start,
  input  wire logic [7:0]  data_in,
  input  wire logic        data_in_valid,
  output logic             data_in_ready,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  write_eeprom_if.master   i2c
);

  localparam int c_timer_w = $clog2(T_WR_CYCLES + 1);

  eeprom_state_t        r_state;
  logic [6:0]           r_slave_addr;
  logic [7:0]           r_nbytes;
  logic [7:0]           r_fetched;
  logic [7:0]           r_sent;
  logic                 r_buf_full;
  logic [7:0]           r_buf_data;
  logic                 r_req_wait;
  logic [c_timer_w-1:0] r_timer;
  logic                 r_done;
  logic                 r_underrun;
  logic [6:0]           r_i2c_slave_addr;
  logic [7:0]           r_i2c_data;
  logic [7:0]           r_i2c_nbytes;
  logic                 r_i2c_start;

  logic [15:0]          w_addr;
  logic [7:0]           w_remaining;
  logic [7:0]           w_chunk;
  logic                 w_req_rise;
  logic                 w_load;
  logic                 w_last;
  logic                 w_advance;
  logic                 w_ready;
  logic                 w_accept;

  assign w_req_rise = i2c.i2c_tx_data_req && !r_req_wait;
  assign w_load     = (r_state == IDLE) && start && (write_nbytes_w != 8'd0);
  assign w_last     = (r_sent == w_chunk - 8'd1);
  assign w_advance  = (r_state == DATA) && w_req_rise && w_last;
  assign w_ready    = (r_state != IDLE) && !r_buf_full && (r_fetched < r_nbytes);
  assign w_accept   = data_in_valid && w_ready;

  eeprom_page_splitter #(
    .PAGE_SIZE (PAGE_SIZE)
  ) u_splitter (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .load_addr  (mem_addr_w),
    .load_count (write_nbytes_w),
    .advance    (w_advance),
    .addr       (w_addr),
    .remaining  (w_remaining),
    .chunk      (w_chunk)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_slave_addr     <= 7'h00;
      r_nbytes         <= 8'h00;
      r_fetched        <= 8'h00;
      r_sent           <= 8'h00;
      r_buf_full       <= 1'b0;
      r_buf_data       <= 8'h00;
      r_req_wait       <= 1'b0;
      r_timer          <= '0;
      r_done           <= 1'b0;
      r_underrun       <= 1'b0;
      r_i2c_slave_addr <= 7'h00;
      r_i2c_data       <= 8'h00;
      r_i2c_nbytes     <= 8'h00;
      r_i2c_start      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!i2c.i2c_tx_data_req) begin
        r_req_wait <= 1'b0;
      end
      // Buffer cannot fill and drain in one cycle: ready implies empty
      if (w_accept) begin
        r_buf_data <= data_in;
        r_buf_full <= 1'b1;
        r_fetched  <= r_fetched + 8'd1;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_underrun <= 1'b0;
            if (write_nbytes_w == 8'd0) begin
              r_done <= 1'b1;
            end else begin
              r_slave_addr <= slave_addr_w;
              r_nbytes     <= write_nbytes_w;
              r_fetched    <= 8'h00;
              r_buf_full   <= 1'b0;
              r_state      <= START;
            end
          end
        end

        START: begin
          r_i2c_slave_addr <= r_slave_addr;
          r_i2c_nbytes     <= w_chunk + 8'(ADDR_BYTES);
          r_i2c_start      <= 1'b1;
          r_sent           <= 8'h00;
          r_state          <= ADDR_HI;
        end

        ADDR_HI: begin
          if (w_req_rise) begin
            r_req_wait <= 1'b1;
            r_i2c_data <= w_addr[15:8];
            r_state    <= ADDR_LO;
          end
        end

        ADDR_LO: begin
          if (w_req_rise) begin
            r_req_wait <= 1'b1;
            r_i2c_data <= w_addr[7:0];
            r_state    <= DATA;
          end
        end

        DATA: begin
          if (w_req_rise) begin
            r_req_wait <= 1'b1;
            if (r_buf_full) begin
              r_i2c_data <= r_buf_data;
              r_buf_full <= 1'b0;
            end else begin
              // No stall path in the master: send filler and flag it
              r_i2c_data <= 8'hFF;
              r_underrun <= 1'b1;
            end
            if (w_last) begin
              r_i2c_start <= 1'b0;
              r_state     <= WAIT_STOP;
            end else begin
              r_sent <= r_sent + 8'd1;
            end
          end
        end

        WAIT_STOP: begin
          if (!i2c.i2c_busy) begin
            r_timer <= c_timer_w'(T_WR_CYCLES);
            r_state <= WRITE_CYCLE;
          end
        end

        WRITE_CYCLE: begin
          if (r_timer == '0) begin
            if (w_remaining != 8'd0) begin
              r_state <= START;
            end else begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_timer <= r_timer - c_timer_w'(1);
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_in_ready      = w_ready;
  assign busy               = (r_state != IDLE);
  assign done               = r_done;
  assign underrun           = r_underrun;
  assign i2c.i2c_slave_addr = r_i2c_slave_addr;
  assign i2c.i2c_rw         = WRITE;
  assign i2c.i2c_write_data = r_i2c_data;
  assign i2c.i2c_nbytes     = r_i2c_nbytes;
  assign i2c.i2c_start      = r_i2c_start;

endmodule
`default_nettype wire
